// File: rtl/rv_pkg.sv
// Shared architectural constants and types for the RV datapath blocks.
// Holds the register width and count, plus the word and register-index types.
package rv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_COUNT = 32;

    typedef logic [4:0]      reg_addr_t;
    typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/register_n.sv
// N-bit D flip-flop with synchronous active-high reset and load enable.
// Used as one architectural register slot inside register_file.
module register_n #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with x0 hardwired to zero.
// Optional same-cycle write-to-read forwarding is built when REGFILE_BYPASS_EN is defined.
module register_file
    import rv_pkg::*;
#(
    parameter  int N     = XLEN,
    parameter  int DEPTH = REG_COUNT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr_1,
    output logic [N-1:0]  rd_data_1,
    input  logic [AW-1:0] rd_addr_2,
    output logic [N-1:0]  rd_data_2
);

    logic [N-1:0] regs [DEPTH];

    // Slot 0 is a constant; no flop exists there, so writes to x0 vanish.
    assign regs[0] = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_reg
        register_n #(.N(N)) u_reg (
            .clk (clk),
            .rst (rst),
            .en  (wr_en && (wr_addr == AW'(i))),
            .d   (wr_data),
            .q   (regs[i])
        );
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_ok;
    assign fwd_ok = wr_en && !rst && (wr_addr != '0);
`endif

    always_comb begin
        rd_data_1 = regs[rd_addr_1];
        rd_data_2 = regs[rd_addr_2];
`ifdef REGFILE_BYPASS_EN
        // The in-flight write wins over the stored value; x0 is excluded via fwd_ok.
        if (fwd_ok && (rd_addr_1 == wr_addr)) begin
            rd_data_1 = wr_data;
        end
        if (fwd_ok && (rd_addr_2 == wr_addr)) begin
            rd_data_2 = wr_data;
        end
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: the driver queues expected read data, the monitor checks it.
// Expected values follow the REGFILE_BYPASS_EN build setting.
module tb_register_file;
    import rv_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic      clk;
    logic      rst;
    logic      wr_en;
    reg_addr_t wr_addr;
    word_t     wr_data;
    reg_addr_t rd_addr_1;
    word_t     rd_data_1;
    reg_addr_t rd_addr_2;
    word_t     rd_data_2;

    word_t     exp1_q [$];
    word_t     exp2_q [$];
    string     name_q [$];

    word_t     ref_regs [REG_COUNT];
    int        checks = 0;
    int        passes = 0;
    bit        random_phase = 1'b0;

    register_file dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_1 (rd_addr_1),
        .rd_data_1 (rd_data_1),
        .rd_addr_2 (rd_addr_2),
        .rd_data_2 (rd_data_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge and optionally queue the expected reads.
    task automatic applyStimulus(input bit r, input bit we, input reg_addr_t wa, input word_t wd,
                                 input reg_addr_t ra1, input reg_addr_t ra2,
                                 input bit chk, input word_t e1, input word_t e2, input string nm);
        @(posedge clk);
        #1;
        rst       = r;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_addr_1 = ra1;
        rd_addr_2 = ra2;
        if (chk) begin
            exp1_q.push_back(e1);
            exp2_q.push_back(e2);
            name_q.push_back(nm);
        end
    endtask

    task automatic checkOutput(input string nm, input word_t actual, input word_t expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", nm, actual, expected);
            if (random_phase) begin
                $display("%0d/%0d checks passed", passes, checks);
                $fatal(1, "[TB] random phase mismatch");
            end
        end
    endtask

    // Monitor: read ports are combinational, so sample mid-cycle whenever an expectation is queued.
    always @(negedge clk) begin
        if (exp1_q.size() > 0) begin
            string nm;
            word_t e1;
            word_t e2;
            nm = name_q.pop_front();
            e1 = exp1_q.pop_front();
            e2 = exp2_q.pop_front();
            checkOutput({nm, "/port1"}, rd_data_1, e1);
            checkOutput({nm, "/port2"}, rd_data_2, e2);
        end
    end

    // Expected read of one port against the reference model, including forwarding when built in.
    function automatic word_t modelRead(input bit r, input bit we, input reg_addr_t wa,
                                        input word_t wd, input reg_addr_t ra);
        if (BYPASS && !r && we && wa != 5'd0 && ra == wa) begin
            return wd;
        end
        return ref_regs[ra];
    endfunction

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr_1 = '0; rd_addr_2 = '0;

        applyStimulus(1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 32'h0, 32'h0, "init_reset");
        applyStimulus(0, 1, 5'd5, 32'h11111111, 5'd1, 5'd2, 1, 32'h0, 32'h0, "post_reset_zero");
        applyStimulus(0, 1, 5'd9, 32'h22222222, 5'd5, 5'd31, 1, 32'h11111111, 32'h0, "pre_reset_write");
        applyStimulus(1, 0, 5'd0, 32'h0, 5'd5, 5'd9, 1, 32'h11111111, 32'h22222222, "reset_cycle_old");

        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1, 32'h0, 32'h0, "reset_all_zero");
        end

        applyStimulus(0, 1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd1, 1, 32'h0, 32'h0, "write_x5");
        applyStimulus(0, 1, 5'd31, 32'h12345678, 5'd5, 5'd0, 1, 32'hDEADBEEF, 32'h0, "write_x31");
        applyStimulus(0, 0, 5'd0, 32'h0, 5'd5, 5'd31, 1, 32'hDEADBEEF, 32'h12345678, "read_x5_x31");

        applyStimulus(0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1, 32'h0, 32'h0, "x0_write_same");
        applyStimulus(0, 0, 5'd0, 32'h0, 5'd0, 5'd5, 1, 32'h0, 32'hDEADBEEF, "x0_after");
        applyStimulus(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 32'h0, 32'h0, "x0_later");

        applyStimulus(0, 1, 5'd7, 32'h1, 5'd7, 5'd7, 1,
                      BYPASS ? 32'h1 : 32'h0, BYPASS ? 32'h1 : 32'h0, "x7_first");
        applyStimulus(0, 1, 5'd7, 32'h2, 5'd7, 5'd7, 1,
                      BYPASS ? 32'h2 : 32'h1, BYPASS ? 32'h2 : 32'h1, "x7_same_cycle");
        applyStimulus(0, 0, 5'd0, 32'h0, 5'd7, 5'd7, 1, 32'h2, 32'h2, "x7_next");

        applyStimulus(0, 0, 5'd7, 32'h55, 5'd7, 5'd31, 1, 32'h2, 32'h12345678, "wr_en_low");
        applyStimulus(0, 0, 5'd0, 32'h0, 5'd7, 5'd7, 1, 32'h2, 32'h2, "wr_en_low_after");

        applyStimulus(0, 1, 5'd3, 32'h0BADF00D, 5'd1, 5'd2, 1, 32'h0, 32'h0, "write_x3");
        applyStimulus(1, 1, 5'd3, 32'hAAAA5555, 5'd3, 5'd7, 1, 32'h0BADF00D, 32'h2, "reset_with_write");
        applyStimulus(0, 0, 5'd0, 32'h0, 5'd3, 5'd7, 1, 32'h0, 32'h0, "reset_priority");

        for (int i = 0; i < REG_COUNT; i++) ref_regs[i] = '0;
        random_phase = 1'b1;
        for (int it = 0; it < 1000; it++) begin
            bit        r;
            bit        we;
            reg_addr_t wa;
            word_t     wd;
            reg_addr_t ra1;
            reg_addr_t ra2;
            r   = ($urandom_range(0, 49) == 0);
            we  = $urandom_range(0, 1) == 1;
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom();
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            applyStimulus(r, we, wa, wd, ra1, ra2, 1,
                          modelRead(r, we, wa, wd, ra1), modelRead(r, we, wa, wd, ra2), "random");
            if (r) begin
                for (int i = 0; i < REG_COUNT; i++) ref_regs[i] = '0;
            end else if (we && wa != 5'd0) begin
                ref_regs[wa] = wd;
            end
        end

        for (int k = 0; k < 10 && exp1_q.size() > 0; k++) @(negedge clk);
        @(posedge clk);
        if (exp1_q.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp1_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter N, default 32: data width of every register and port, in bits.
REQ-002 Parameter DEPTH, default 32: number of architectural registers; must be a power of two.
REQ-003 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: synchronous active-high reset, sampled on the clk rising edge.
REQ-005 Port wr_en, input, 1: write enable for the single write port.
REQ-006 Port wr_addr, input, $clog2(DEPTH): write register index.
REQ-007 Port wr_data, input, N: write data.
REQ-008 Port rd_addr_1, input, $clog2(DEPTH): read port 1 register index.
REQ-009 Port rd_data_1, output, N: read port 1 data, fed to the downstream operand select muxes.
REQ-010 Port rd_addr_2, input, $clog2(DEPTH): read port 2 register index.
REQ-011 Port rd_data_2, output, N: read port 2 data, fed to the downstream operand select muxes.

Function
REQ-012 Storage: DEPTH registers of N bits each, held in flip-flops.
REQ-013 Writes: at a clk rising edge with rst=0, wr_en=1 and wr_addr!=0, register[wr_addr] takes wr_data; it is visible on the read ports from the next cycle.
REQ-014 Writes with wr_en=0 leave every register unchanged.
REQ-015 Register 0: reads as 0 at all times; writes to index 0 are discarded with no side effect.
REQ-016 Reads: rd_data_1 and rd_data_2 are combinational (zero-cycle latency) functions of the read addresses and the stored state.
REQ-017 Both read ports may address the same register in the same cycle; both return identical data.
REQ-018 A read of wr_addr in the cycle it is being written returns the old value, unless REGFILE_BYPASS_EN is defined (REQ-024).
REQ-019 No X propagation: every output is a defined 0/1 value whenever all inputs are defined.

Reset
REQ-020 At a clk rising edge with rst=1, all DEPTH registers clear to 0, so rd_data_1 and rd_data_2 read 0 from the next cycle.
REQ-021 rst has priority over wr_en: a write presented in the same cycle as rst is dropped.
REQ-022 Asserting rst mid-operation aborts no multi-cycle transaction, because none exists; state is simply cleared.

Configuration
REQ-023 Macro REGFILE_BYPASS_EN compiles in write-to-read forwarding.
REQ-024 With REGFILE_BYPASS_EN defined: when wr_en=1, rst=0, wr_addr!=0 and rd_addr_k==wr_addr, rd_data_k equals wr_data in that same cycle. Register 0 still reads 0 and rst=1 suppresses forwarding.
REQ-025 Without REGFILE_BYPASS_EN: no forwarding path is present; REQ-018 old-value behaviour holds.

Structure
REQ-026 The shared package rv_pkg holds: constant XLEN=32, constant REG_COUNT=32, typedef reg_addr_t (5 bits) and typedef word_t (XLEN bits).
REQ-027 Each register is one instance of sub-module register_n (N-bit D flip-flop with synchronous active-high rst and enable); register_file generates DEPTH-1 instances, and index 0 is a constant 0.
REQ-028 Read selection uses a DEPTH:1 selection per port, built from the existing mux primitives or an equivalent indexed read.

Verification
REQ-029 Reset: rst=1 for one edge after arbitrary writes; read all 32 indices on both ports -> all 0x00000000.
REQ-030 Write/read: write 0xDEADBEEF to x5, then 0x12345678 to x31; next cycle rd_addr_1=5, rd_addr_2=31 -> 0xDEADBEEF and 0x12345678.
REQ-031 x0 protection: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF -> rd_data_1 for index 0 reads 0x00000000 in every later cycle.
REQ-032 Same-cycle write/read of x7 (old value 0x1, new value 0x2) -> 0x1 without REGFILE_BYPASS_EN; 0x2 with it; 0x2 on the following cycle in both builds.
REQ-033 Reset priority: rst=1 together with wr_en=1, wr_addr=3, wr_data=0xAAAA5555 -> x3 reads 0 the next cycle.
REQ-034 Random: 1000 iterations of random writes and reads against a reference array model; assert equality on both ports every cycle, $fatal on mismatch.
